// File: rtl/decoder_pipe.sv
// decoder_pipe: binary index to one-hot / thermometer / inverted one-hot code,
// carried through STAGES elastic register stages with valid/ready handshaking.
// Also keeps a saturating output-handshake counter and a sticky illegal-mode flag.
module decoder_pipe #(
  parameter int N_IN   = 5,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         a,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [(1<<N_IN)-1:0]    y,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        txn_count,
  output logic                    mode_err
);

  localparam int               W       = 1 << N_IN;
  localparam logic [W-1:0]     ONE     = W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Thermometer code is the one-hot shifted up by one minus one; when the
  // one-hot sits in the top bit the shift wraps to zero and the subtraction
  // yields all ones, which is exactly the required a = W-1 result.
  function automatic logic [W-1:0] decode(input logic [N_IN-1:0] idx,
                                          input logic [1:0]      md);
    logic [W-1:0] onehot;
    onehot = ONE << idx;
    case (md)
      2'b00:   decode = onehot;
      2'b01:   decode = (onehot << 1) - ONE;
      2'b10:   decode = ~onehot;
      default: decode = '0;
    endcase
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] adv, ld;
  logic [STAGES-1:0] src_vld;
  logic [W-1:0]      y_q   [STAGES];
  logic [W-1:0]      y_d   [STAGES];
  logic [W-1:0]      src_y [STAGES];
  logic [CNT_W-1:0]  txn_q, txn_d;
  logic              err_q, err_d;
  logic              hs_in, hs_out;

  // Ready chain from the output back to stage 0: a stage may load when it is
  // empty or its occupant moves on this cycle.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    adv = '0;
    ld  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld_q[k] & r;
      r      = ~vld_q[k] | r;
      ld[k]  = r;
    end
  end

  assign in_ready  = ld[0];
  assign hs_in     = in_valid & in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign hs_out    = out_valid & out_ready;
  assign txn_count = txn_q;
  assign mode_err  = err_q;

  // Each stage's source: the decoder for stage 0, the previous stage otherwise.
  always_comb begin
    src_vld[0] = in_valid;
    src_y[0]   = decode(a, mode);
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_y[k]   = y_q[k-1];
    end
  end

  // Stage next-state; data only moves when a valid item arrives so y keeps
  // its last value while the stage is empty.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = ld[k] ? src_vld[k] : vld_q[k];
      y_d[k]   = (ld[k] & src_vld[k]) ? src_y[k] : y_q[k];
    end
  end

  // Saturating handshake counter (clear wins) and sticky illegal-mode flag.
  always_comb begin
    txn_d = txn_q;
    if (cnt_clr) begin
      txn_d = '0;
    end else if (hs_out && (txn_q != CNT_MAX)) begin
      txn_d = txn_q + CNT_W'(1);
    end
    err_d = err_q | (hs_in & (mode == 2'b11));
  end

  // State registers; reset discards everything in flight, including data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) y_q[k] <= '0;
      txn_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) y_q[k] <= y_d[k];
      txn_q <= txn_d;
      err_q <= err_d;
    end
  end

endmodule
